// File: rtl/lcd_pcf8574_sequencer_if.sv
// ---------------------------------------------------------------------------
// lcd_pcf8574_sequencer_if
// Bundles the upstream command handshake, the byte-level I2C master handshake
// and the sequencer status pulses into one interface.
//   cmd_valid/cmd_ready : upstream byte request / accept (ready only in IDLE)
//   cmd_rs, cmd_byte    : register select and LCD byte
//   backlight           : BL bit value, captured together with cmd_byte
//   i2c_start/i2c_data  : start pulse and PCF8574 byte {D7..D4, BL, E, RW, RS}
//   i2c_busy/i2c_done   : I2C master busy level and completion pulse
//   busy, seq_done, err : sequencer status
// Modports: slave = the sequencer, master = the side driving it.
// ---------------------------------------------------------------------------
interface lcd_pcf8574_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rs;
    logic [7:0] cmd_byte;
    logic       backlight;
    logic       i2c_start;
    logic [7:0] i2c_data;
    logic       i2c_busy;
    logic       i2c_done;
    logic       busy;
    logic       seq_done;
    logic       err;

    modport slave (
        input  cmd_valid, cmd_rs, cmd_byte, backlight, i2c_busy, i2c_done,
        output cmd_ready, i2c_start, i2c_data, busy, seq_done, err
    );

    modport master (
        output cmd_valid, cmd_rs, cmd_byte, backlight, i2c_busy, i2c_done,
        input  cmd_ready, i2c_start, i2c_data, busy, seq_done, err
    );
endinterface

// File: rtl/lcd_pcf8574_sequencer.sv
// ---------------------------------------------------------------------------
// lcd_pcf8574_sequencer
// Turns one LCD command/data byte into the four PCF8574 writes needed for
// HD44780 4-bit mode (high nibble E=1/E=0, low nibble E=1/E=0), then waits
// the controller execution time before accepting the next byte.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : lcd_pcf8574_sequencer_if.slave (command handshake, I2C handshake,
//          busy / seq_done / err status)
// Parameters:
//   DELAY_SHORT : post-byte wait for ordinary commands and data (clk cycles)
//   DELAY_LONG  : post-byte wait for clear / home commands (clk cycles)
//   TIMEOUT     : max cycles to wait for i2c_done per I2C byte
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a new byte
// ISSUE     | i2c_data set up for current phase, waiting for !i2c_busy
// WAIT_DONE | start issued, waiting for i2c_done (timeout running)
// DELAY     | all four writes done, waiting LCD execution time
// ---------------------------------------------------------------------------
module lcd_pcf8574_sequencer #(
    parameter int DELAY_SHORT = 5000,
    parameter int DELAY_LONG  = 200000,
    parameter int TIMEOUT     = 2000000
) (
    input  logic                        clk,
    input  logic                        rst,
    lcd_pcf8574_sequencer_if.slave      bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, DELAY} state_t;

    localparam int CNT_MAX = (DELAY_LONG > TIMEOUT) ? DELAY_LONG : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // The delay counter is loaded on the cycle i2c_done is sampled, so the
    // load value is one less than the wait so that seq_done lands exactly
    // DELAY_x cycles after the done pulse.
    localparam logic [CNT_W-1:0] DLY_SHORT_LD = CNT_W'(DELAY_SHORT - 1);
    localparam logic [CNT_W-1:0] DLY_LONG_LD  = CNT_W'(DELAY_LONG - 1);
    localparam logic [CNT_W-1:0] TMO_LAST     = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nx;
    logic [1:0]       phase, phase_nx;
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nx;
    logic [CNT_W-1:0] dly_cnt, dly_cnt_nx;
    logic             rs_q, rs_nx;
    logic             bl_q, bl_nx;
    logic             long_q, long_nx;
    logic [7:0]       byte_q, byte_nx;
    logic [7:0]       data_q, data_nx;
    logic             start_q, start_nx;
    logic             seq_done_q, seq_done_nx;
    logic             err_q, err_nx;

    // PCF8574 byte for a given phase: even phases raise E, odd phases drop it;
    // phases 0/1 carry the high nibble, 2/3 the low nibble. RW is always 0.
    function automatic logic [7:0] pcf_byte(input logic [1:0] ph,
                                            input logic [7:0] b,
                                            input logic       bl,
                                            input logic       rs);
        logic [3:0] nib;
        nib = ph[1] ? b[3:0] : b[7:4];
        return {nib, bl, ~ph[0], 1'b0, rs};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= 2'd0;
            tmo_cnt    <= '0;
            dly_cnt    <= '0;
            rs_q       <= 1'b0;
            bl_q       <= 1'b0;
            long_q     <= 1'b0;
            byte_q     <= 8'h00;
            data_q     <= 8'h00;
            start_q    <= 1'b0;
            seq_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nx;
            phase      <= phase_nx;
            tmo_cnt    <= tmo_cnt_nx;
            dly_cnt    <= dly_cnt_nx;
            rs_q       <= rs_nx;
            bl_q       <= bl_nx;
            long_q     <= long_nx;
            byte_q     <= byte_nx;
            data_q     <= data_nx;
            start_q    <= start_nx;
            seq_done_q <= seq_done_nx;
            err_q      <= err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        phase_nx    = phase;
        tmo_cnt_nx  = tmo_cnt;
        dly_cnt_nx  = dly_cnt;
        rs_nx       = rs_q;
        bl_nx       = bl_q;
        long_nx     = long_q;
        byte_nx     = byte_q;
        data_nx     = data_q;
        start_nx    = 1'b0;
        seq_done_nx = 1'b0;
        err_nx      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    rs_nx    = bus.cmd_rs;
                    bl_nx    = bus.backlight;
                    byte_nx  = bus.cmd_byte;
                    long_nx  = !bus.cmd_rs &&
                               (bus.cmd_byte inside {8'h01, 8'h02, 8'h03});
                    phase_nx = 2'd0;
                    data_nx  = pcf_byte(2'd0, bus.cmd_byte, bus.backlight, bus.cmd_rs);
                    state_nx = ISSUE;
                end
            end

            ISSUE: begin
                if (!bus.i2c_busy) begin
                    start_nx   = 1'b1;
                    tmo_cnt_nx = '0;
                    state_nx   = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                if (bus.i2c_done) begin
                    if (phase != 2'd3) begin
                        phase_nx = phase + 2'd1;
                        data_nx  = pcf_byte(phase + 2'd1, byte_q, bl_q, rs_q);
                        state_nx = ISSUE;
                    end else begin
                        dly_cnt_nx = long_q ? DLY_LONG_LD : DLY_SHORT_LD;
                        state_nx   = DELAY;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    // Abort: remaining phases and the execution delay are dropped.
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    tmo_cnt_nx = tmo_cnt + CNT_W'(1);
                end
            end

            DELAY: begin
                if (dly_cnt <= CNT_W'(1)) begin
                    seq_done_nx = 1'b1;
                    state_nx    = IDLE;
                end else begin
                    dly_cnt_nx = dly_cnt - CNT_W'(1);
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.i2c_start = start_q;
    assign bus.i2c_data  = data_q;
    assign bus.seq_done  = seq_done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_lcd_pcf8574_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lcd_pcf8574_sequencer
// Scoreboard bench: the driver pushes the expected PCF8574 bytes and the
// expected completion event (seq_done with its delay, or err) when it issues
// a command; an independent monitor pops and compares whenever the DUT
// presents i2c_start, seq_done or err. A small I2C master model answers each
// start with a done pulse after a configurable latency.
// ---------------------------------------------------------------------------
module tb_lcd_pcf8574_sequencer;

    localparam int DELAY_SHORT = 40;
    localparam int DELAY_LONG  = 150;
    localparam int TIMEOUT     = 200;

    typedef struct {
        bit is_err;
        int delay;
    } evt_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_pcf8574_sequencer_if bus();

    lcd_pcf8574_sequencer #(
        .DELAY_SHORT (DELAY_SHORT),
        .DELAY_LONG  (DELAY_LONG),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic model_done = 1'b0;
    logic stray_done = 1'b0;
    assign bus.i2c_done = model_done | stray_done;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int n_starts = 0;
    int n_seq = 0;
    int n_err = 0;
    int model_starts = 0;
    int drop_target = -1;
    int done_lat = 20;
    int stray_base = 0;
    int pushed = 0;
    bit stray_en = 1'b0;
    bit outstanding = 1'b0;
    int last_done_cyc = 0;
    int last_start_cyc = 0;

    logic [7:0] exp_bytes[$];
    evt_t       exp_evt[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    // Reference: byte i of the sequence carries the high nibble for i<2,
    // the low nibble otherwise; E is set on even writes.
    function automatic void push_expect(input bit rs, input int b, input bit bl,
                                        input int nbytes, input int kind);
        evt_t ev;
        for (int i = 0; i < nbytes; i++) begin
            int nib;
            int e;
            nib = (i < 2) ? b / 16 : b % 16;
            e   = (i % 2 == 0) ? 1 : 0;
            exp_bytes.push_back(8'(nib * 16 + int'(bl) * 8 + e * 4 + int'(rs)));
        end
        pushed += nbytes;
        if (kind == 0) begin
            ev.is_err = 1'b0;
            ev.delay  = (!rs && b >= 1 && b <= 3) ? DELAY_LONG : DELAY_SHORT;
            exp_evt.push_back(ev);
        end else if (kind == 1) begin
            ev.is_err = 1'b1;
            ev.delay  = TIMEOUT;
            exp_evt.push_back(ev);
        end
    endfunction

    // Monitor / scoreboard
    initial begin
        evt_t ev;
        forever begin
            @(negedge clk);
            if (rst) begin
                outstanding = 1'b0;
            end else begin
                if (bus.i2c_done && outstanding) begin
                    outstanding   = 1'b0;
                    last_done_cyc = cyc;
                end
                if (bus.i2c_start) begin
                    check("start_overlap", 32'(outstanding), 32'd0);
                    if (exp_bytes.size() == 0) fail_now("unexpected_start");
                    else check("i2c_data", 32'(bus.i2c_data), 32'(exp_bytes.pop_front()));
                    outstanding    = 1'b1;
                    last_start_cyc = cyc;
                    n_starts++;
                end
                if (bus.seq_done) begin
                    n_seq++;
                    if (exp_evt.size() == 0) fail_now("unexpected_seq_done");
                    else begin
                        ev = exp_evt.pop_front();
                        check("seq_done_kind", 32'(ev.is_err), 32'd0);
                        check("seq_done_delay", 32'(cyc - last_done_cyc), 32'(ev.delay));
                        check("ready_at_seq_done", 32'(bus.cmd_ready), 32'd1);
                    end
                end
                if (bus.err) begin
                    n_err++;
                    outstanding = 1'b0;
                    if (exp_evt.size() == 0) fail_now("unexpected_err");
                    else begin
                        ev = exp_evt.pop_front();
                        check("err_kind", 32'(ev.is_err), 32'd1);
                        check("err_delay", 32'(cyc - last_start_cyc), 32'(ev.delay));
                    end
                end
            end
        end
    end

    // I2C master model
    initial begin
        forever begin
            @(negedge clk);
            if (bus.i2c_start && !rst) begin
                model_starts++;
                if (model_starts != drop_target) begin
                    repeat (done_lat) @(posedge clk);
                    #1 model_done = 1'b1;
                    @(posedge clk);
                    #1 model_done = 1'b0;
                    if (stray_en && ((model_starts - stray_base) % 4 == 0)) begin
                        repeat (5) @(posedge clk);
                        #1 stray_done = 1'b1;
                        @(posedge clk);
                        #1 stray_done = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send(input bit rs, input logic [7:0] b, input bit bl,
                        input int nbytes, input int kind, input bit keep_valid);
        int n;
        push_expect(rs, int'(b), bl, nbytes, kind);
        bus.cmd_valid = 1'b1;
        bus.cmd_rs    = rs;
        bus.cmd_byte  = b;
        bus.backlight = bl;
        n = 0;
        while (!bus.cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            $display("FAIL accept_timeout: cmd_ready never rose");
            $fatal(1);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = keep_valid;
        bus.cmd_rs    = 1'($urandom);
        bus.cmd_byte  = 8'($urandom);
        bus.backlight = 1'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!(bus.cmd_ready && exp_evt.size() == 0 && exp_bytes.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(n < budget), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        int base_s;
        int base_q;
        int base_e;
        int n;

        bus.cmd_valid = 1'b0;
        bus.cmd_rs    = 1'b0;
        bus.cmd_byte  = 8'h00;
        bus.backlight = 1'b0;
        bus.i2c_busy  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_data", 32'(bus.i2c_data), 32'h00);
        check("rst_start", 32'(bus.i2c_start), 32'd0);
        check("rst_seq_done", 32'(bus.seq_done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Data byte, clear, ordinary command
        send(1'b1, 8'h48, 1'b1, 4, 0, 1'b0);
        wait_idle(2000);
        check("idle_after_seq", 32'(bus.cmd_ready), 32'd1);
        send(1'b0, 8'h01, 1'b1, 4, 0, 1'b0);
        wait_idle(2000);
        send(1'b0, 8'h28, 1'b1, 4, 0, 1'b0);
        wait_idle(2000);

        // Backlight off with i2c_busy stall
        bus.i2c_busy = 1'b1;
        send(1'b1, 8'h48, 1'b0, 4, 0, 1'b0);
        base_s = n_starts;
        repeat (100) @(negedge clk);
        check("stall_no_start", 32'(n_starts), 32'(base_s));
        bus.i2c_busy = 1'b0;
        wait_idle(2000);

        // Timeout after the second start, then a normal command
        base_e = n_err;
        drop_target = model_starts + 2;
        send(1'b1, 8'hC3, 1'b1, 2, 1, 1'b0);
        wait_idle(TIMEOUT + 500);
        drop_target = -1;
        check("timeout_err_count", 32'(n_err - base_e), 32'd1);
        send(1'b0, 8'h0C, 1'b1, 4, 0, 1'b0);
        wait_idle(2000);

        // Randomized commands and I2C latencies
        for (int k = 0; k < 10; k++) begin
            bit rs;
            bit bl;
            int b;
            rs = 1'($urandom);
            bl = 1'($urandom);
            b  = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0) begin
                rs = 1'b0;
                b  = $urandom_range(1, 3);
            end
            done_lat = $urandom_range(1, 25);
            send(rs, 8'(b), bl, 4, 0, 1'b0);
            wait_idle(2000);
        end
        done_lat = 20;

        // Back-to-back with cmd_valid held, stray done during DELAY
        base_s = n_starts;
        base_q = n_seq;
        stray_base = model_starts;
        stray_en = 1'b1;
        send(1'b1, 8'h41, 1'b1, 4, 0, 1'b1);
        send(1'b0, 8'h02, 1'b1, 4, 0, 1'b1);
        send(1'b1, 8'h7A, 1'b0, 4, 0, 1'b0);
        wait_idle(3000);
        stray_en = 1'b0;
        check("b2b_starts", 32'(n_starts - base_s), 32'd12);
        check("b2b_seq_done", 32'(n_seq - base_q), 32'd3);

        // Reset during phase-2 WAIT_DONE
        drop_target = model_starts + 3;
        send(1'b1, 8'h5A, 1'b1, 3, 2, 1'b0);
        n = 0;
        while (model_starts < drop_target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("rst_test_reached_phase2", 32'(model_starts >= drop_target), 32'd1);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midop_rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("midop_rst_busy", 32'(bus.busy), 32'd0);
        check("midop_rst_data", 32'(bus.i2c_data), 32'h00);
        @(posedge clk);
        #1 stray_done = 1'b1;
        @(posedge clk);
        #1 stray_done = 1'b0;
        base_s = n_starts;
        repeat (60) @(negedge clk);
        check("late_done_no_start", 32'(n_starts), 32'(base_s));
        check("late_done_idle", 32'(bus.busy), 32'd0);
        drop_target = -1;
        send(1'b1, 8'h33, 1'b1, 4, 0, 1'b0);
        wait_idle(2000);

        check("bytes_left", 32'(exp_bytes.size()), 32'd0);
        check("events_left", 32'(exp_evt.size()), 32'd0);
        check("total_starts", 32'(n_starts), 32'(pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
